// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL and DIV.
// Valid/ready on both sides; results and flags held until taken.
module multicycle_alu #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_div0,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] hi_q, lo_q, op2_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  logic [WIDTH:0]     add_s, sub_d, mul_s, div_sh;
  logic [WIDTH+1:0]   div_d;
  logic [2*WIDTH-1:0] dbl, rol_w, ror_w;
  logic [SW-1:0]      amt;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v, gt;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept) begin
          if (opcode == OP_MUL)      state_n = S_MUL;
          else if (opcode == OP_DIV) state_n = S_DIV;
          else                       state_n = S_DONE;
        end
      S_MUL, S_DIV:
        if (last) state_n = S_DONE;
      S_DONE:
        if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // in_ready is forced low while reset is asserted so every output reads 0
  always_comb begin
    in_ready  = (state == S_IDLE) && reset_n;
    out_valid = (state == S_DONE);
    busy      = (state == S_MUL) || (state == S_DIV);
  end

  always_comb begin
    add_s = {1'b0, operand1} + {1'b0, operand2};
    sub_d = {1'b0, operand1} - {1'b0, operand2};
    amt   = operand2[SW-1:0];
    dbl   = {operand1, operand1};
    rol_w = dbl << amt;
    ror_w = dbl >> amt;
    if (SIGNED_CMP) gt = $signed(operand1) > $signed(operand2);
    else            gt = operand1 > operand2;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_r = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_v = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                (add_s[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = sub_d[WIDTH-1:0];
        alu_c = sub_d[WIDTH];
        alu_v = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                (sub_d[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SHL:  alu_r = operand1 << amt;
      OP_SHR:  alu_r = operand1 >> amt;
      OP_ROL:  alu_r = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_r = ror_w[WIDTH-1:0];
      OP_AND:  alu_r = operand1 & operand2;
      OP_OR:   alu_r = operand1 | operand2;
      OP_XOR:  alu_r = operand1 ^ operand2;
      OP_NOR:  alu_r = ~(operand1 | operand2);
      OP_NAND: alu_r = ~(operand1 & operand2);
      OP_XNOR: alu_r = ~(operand1 ^ operand2);
      OP_GT:   alu_r = {{(WIDTH-1){1'b0}}, gt};
      OP_EQ:   alu_r = {{(WIDTH-1){1'b0}}, operand1 == operand2};
      default: alu_r = '0;
    endcase
  end

  // one shift-add or restoring-divide step; {hi,lo} is the working pair
  always_comb begin
    mul_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op2_q} : '0);
    div_sh = {hi_q, lo_q[WIDTH-1]};
    div_d  = {1'b0, div_sh} - {2'b00, op2_q};
    if (state == S_MUL) begin
      hi_n = mul_s[WIDTH:1];
      lo_n = {mul_s[0], lo_q[WIDTH-1:1]};
    end else if (div_d[WIDTH+1]) begin
      hi_n = div_sh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      hi_n = div_d[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q          <= '0;
      lo_q          <= '0;
      op2_q         <= '0;
      cnt           <= '0;
      result        <= '0;
      result_hi     <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      flag_div0     <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      hi_q  <= '0;
      lo_q  <= operand1;
      op2_q <= operand2;
      cnt   <= '0;
      if (opcode != OP_MUL && opcode != OP_DIV) begin
        result        <= alu_r;
        result_hi     <= '0;
        flag_zero     <= (alu_r == '0);
        flag_carry    <= alu_c;
        flag_overflow <= alu_v;
        flag_div0     <= 1'b0;
      end
    end else if (busy) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      cnt  <= cnt + 1'b1;
      if (last) begin
        result        <= lo_n;
        result_hi     <= hi_n;
        flag_zero     <= (lo_n == '0);
        flag_carry    <= 1'b0;
        flag_overflow <= 1'b0;
        flag_div0     <= (state == S_DIV) && (op2_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=16.
// Expected results come from a behavioural model using native operators.
module tb_multicycle_alu;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         z;
    logic         c;
    logic         v;
    logic         d;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result, result_hi;
  logic         flag_zero, flag_carry, flag_overflow, flag_div0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  multicycle_alu #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_overflow(flag_overflow), .flag_div0(flag_div0),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int unsigned ua, ub;
    int sa, sb2, s;
    logic [31:0] t;
    logic [W-1:0] x;
    ua = 32'(a);
    ub = 32'(b);
    sa = int'($signed(a));
    sb2 = int'($signed(b));
    e = '0;
    x = a;
    case (op)
      4'd0: begin
        t = ua + ub;
        e.r = t[W-1:0];
        e.c = t[16];
        s = sa + sb2;
        e.v = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        t = ua - ub;
        e.r = t[W-1:0];
        e.c = ua < ub;
        s = sa - sb2;
        e.v = (s > 32767) || (s < -32768);
      end
      4'd2: begin
        t = ua * ub;
        e.r = t[15:0];
        e.h = t[31:16];
      end
      4'd3: begin
        if (b == 0) begin
          e.r = 16'hFFFF;
          e.h = a;
          e.d = 1'b1;
        end else begin
          t = ua / ub;
          e.r = t[15:0];
          t = ua % ub;
          e.h = t[15:0];
        end
      end
      4'd4: e.r = a << b[3:0];
      4'd5: e.r = a >> b[3:0];
      4'd6: begin
        for (int i = 0; i < int'(b[3:0]); i++) x = {x[14:0], x[15]};
        e.r = x;
      end
      4'd7: begin
        for (int i = 0; i < int'(b[3:0]); i++) x = {x[0], x[15:1]};
        e.r = x;
      end
      4'd8:  e.r = a & b;
      4'd9:  e.r = a | b;
      4'd10: e.r = a ^ b;
      4'd11: e.r = ~(a | b);
      4'd12: e.r = ~(a & b);
      4'd13: e.r = ~(a ^ b);
      4'd14: e.r = (ua > ub) ? 16'd1 : 16'd0;
      default: e.r = (a == b) ? 16'd1 : 16'd0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, "_result"}, 32'(result), 32'(e.r));
    chk({tag, "_hi"}, 32'(result_hi), 32'(e.h));
    chk({tag, "_zero"}, 32'(flag_zero), 32'(e.z));
    chk({tag, "_carry"}, 32'(flag_carry), 32'(e.c));
    chk({tag, "_ovf"}, 32'(flag_overflow), 32'(e.v));
    chk({tag, "_div0"}, 32'(flag_div0), 32'(e.d));
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int hold,
                     input bit pre_rdy);
    exp_t e;
    int lat, bcnt, want;
    @(negedge clock);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    opcode = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    out_ready = pre_rdy;
    @(posedge clock);
    sb.push_back(model(op, a, b));
    #1;
    in_valid = 1'b0;
    opcode = ~op;
    operand1 = ~a;
    operand2 = ~b;
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clock);
      #1;
      lat++;
    end
    want = (op == 4'd2 || op == 4'd3) ? W + 1 : 1;
    chk("latency", 32'(lat), 32'(want));
    chk("busy_cycles", 32'(bcnt), 32'(want - 1));
    e = sb.pop_front();
    cmp_out("out", e);
    if (hold > 0) begin
      in_valid = 1'b1;
      opcode = 4'd0;
      operand1 = 16'h1111;
      operand2 = 16'h2222;
    end
    repeat (hold) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      cmp_out("hold", e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("taken_valid", 32'(out_valid), 32'd0);
    chk("taken_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_hi", 32'(result_hi), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    run(4'd0, 16'hFFFF, 16'h0001, 0, 1'b0);
    run(4'd1, 16'h8000, 16'h0001, 0, 1'b0);
    run(4'd1, 16'h0003, 16'h0005, 0, 1'b0);
    run(4'd2, 16'h1234, 16'h0100, 0, 1'b0);
    run(4'd3, 16'd100, 16'd7, 0, 1'b0);
    run(4'd3, 16'h00AB, 16'h0000, 0, 1'b0);
    run(4'd3, 16'd100, 16'd7, 5, 1'b0);
    run(4'd2, 16'hFFFF, 16'hFFFF, 3, 1'b0);
    run(4'd6, 16'h8001, 16'h0000, 0, 1'b1);
    run(4'd6, 16'h8001, 16'h0013, 0, 1'b1);
    run(4'd7, 16'h8001, 16'h0004, 0, 1'b0);
    run(4'd14, 16'h8000, 16'h0001, 0, 1'b0);
    run(4'd15, 16'h5A5A, 16'h5A5A, 0, 1'b0);

    // abort a multiply in its eighth busy cycle
    @(negedge clock);
    opcode = 4'd2;
    operand1 = 16'h1234;
    operand2 = 16'h5678;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_hi", 32'(result_hi), 32'd0);
    chk("abort_zero", 32'(flag_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_rel_ready", 32'(in_ready), 32'd1);
    run(4'd0, 16'd2, 16'd3, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run(4'($urandom_range(0, 15)), 16'($urandom),
          (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
          i % 3, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
